mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
// Memory built-in self-test controller. On start it writes a pattern to every
// location, reads every location back and compares the returned data one cycle
// later. It reports the number of mismatching locations and the first failing
// address.
//
// Optional feature macro: MEM_BIST_STOP_ON_ERR_EN
//   When defined, the first mismatch aborts the test and goes straight to DONE.
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               synchronous active-high reset
//   i_start             one-cycle run request (honoured in IDLE/DONE only)
//   i_mode              pattern select, sampled with i_start
//   i_seed              XOR seed for the address-seeded pattern
//   o_read / o_write    memory strobes (never both high)
//   o_addr              memory address
//   o_data_in           write data to memory
//   i_data_out          read data, valid the cycle after o_read
//   o_busy              test in progress
//   o_done              test finished (level)
//   o_pass              no mismatches (valid while o_done)
//   o_err_count         number of mismatching locations
//   o_first_fail_addr   address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_seed,
    output logic              o_read,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_in,
    input  logic [DATA_W-1:0] i_data_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_count,
    output logic [ADDR_W-1:0] o_first_fail_addr
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   ErrMax   = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0]        mode,
                                                    input logic [DATA_W-1:0] seed,
                                                    input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        case (mode)
            2'b00: p = '0;
            2'b01: p = '1;
            // 0x55 on even addresses, 0xAA on odd ones
            2'b10: for (int i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0) ? ~a[0] : a[0];
            default: p = seed ^ DATA_W'(a);
        endcase
        return p;
    endfunction

    state_e              r_state, w_state_d;
    logic [1:0]          r_mode, w_mode_d;
    logic [DATA_W-1:0]   r_seed, w_seed_d;
    logic                r_read, w_read_d;
    logic                r_write, w_write_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_data_in, w_data_in_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;
    logic                r_pass, w_pass_d;
    logic [ADDR_W:0]     r_err_count, w_err_count_d;
    logic [ADDR_W-1:0]   r_ffa, w_ffa_d;
    // Address of the read issued last cycle; its data is on i_data_out now.
    logic                r_cmp_vld;
    logic [ADDR_W-1:0]   r_cmp_addr;

    logic                w_mismatch;
    logic                w_abort;
    logic [ADDR_W:0]     w_err_next;
    logic [ADDR_W-1:0]   w_ffa_next;

    always_comb begin
        w_mismatch = r_cmp_vld && (r_state == StRead || r_state == StDrain) &&
                     (i_data_out != f_pattern(r_mode, r_seed, r_cmp_addr));
        w_err_next = r_err_count;
        w_ffa_next = r_ffa;
        if (w_mismatch) begin
            if (r_err_count != ErrMax) w_err_next = r_err_count + 1'b1;
            if (r_err_count == '0)     w_ffa_next = r_cmp_addr;
        end
`ifdef MEM_BIST_STOP_ON_ERR_EN
        w_abort = w_mismatch;
`else
        w_abort = 1'b0;
`endif
    end

    always_comb begin
        w_state_d     = r_state;
        w_mode_d      = r_mode;
        w_seed_d      = r_seed;
        w_read_d      = 1'b0;
        w_write_d     = 1'b0;
        w_addr_d      = '0;
        w_data_in_d   = '0;
        w_busy_d      = r_busy;
        w_done_d      = r_done;
        w_pass_d      = r_pass;
        w_err_count_d = w_err_next;
        w_ffa_d       = w_ffa_next;
        case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_d     = StWrite;
                    w_mode_d      = i_mode;
                    w_seed_d      = i_seed;
                    w_write_d     = 1'b1;
                    w_data_in_d   = f_pattern(i_mode, i_seed, '0);
                    w_busy_d      = 1'b1;
                    w_done_d      = 1'b0;
                    w_pass_d      = 1'b0;
                    w_err_count_d = '0;
                    w_ffa_d       = '0;
                end
            end
            StWrite: begin
                if (r_addr == AddrLast) begin
                    w_state_d = StRead;
                    w_read_d  = 1'b1;
                end else begin
                    w_write_d   = 1'b1;
                    w_addr_d    = r_addr + 1'b1;
                    w_data_in_d = f_pattern(r_mode, r_seed, r_addr + 1'b1);
                end
            end
            StRead: begin
                if (w_abort) begin
                    w_state_d = StDone;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_pass_d  = 1'b0;
                end else if (r_addr == AddrLast) begin
                    w_state_d = StDrain;
                end else begin
                    w_read_d = 1'b1;
                    w_addr_d = r_addr + 1'b1;
                end
            end
            StDrain: begin
                w_state_d = StDone;
                w_busy_d  = 1'b0;
                w_done_d  = 1'b1;
                w_pass_d  = (w_err_next == '0);
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_mode      <= '0;
            r_seed      <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data_in   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_ffa       <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_addr  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_mode      <= w_mode_d;
            r_seed      <= w_seed_d;
            r_read      <= w_read_d;
            r_write     <= w_write_d;
            r_addr      <= w_addr_d;
            r_data_in   <= w_data_in_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_pass      <= w_pass_d;
            r_err_count <= w_err_count_d;
            r_ffa       <= w_ffa_d;
            r_cmp_vld   <= r_read;
            r_cmp_addr  <= r_addr;
        end
    end

    assign o_read            = r_read;
    assign o_write           = r_write;
    assign o_addr            = r_addr;
    assign o_data_in         = r_data_in;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_err_count       = r_err_count;
    assign o_first_fail_addr = r_ffa;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_ctrl
// Self-checking bench for mem_bist_ctrl with a behavioural memory that can
// return corrupted data at chosen addresses. Expected strobes, addresses, data
// and results are derived from the pattern rules and the fault map.
// -----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seed;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [4:0] ffa;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem       [32];
    logic       fault_en  [32];
    logic [7:0] fault_val [32];

    always #5 clk = ~clk;

    mem_bist_ctrl #(
        .ADDR_W(5),
        .DATA_W(8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_mode           (mode),
        .i_seed           (seed),
        .o_read           (rd),
        .o_write          (wr),
        .o_addr           (addr),
        .o_data_in        (din),
        .i_data_out       (dout),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_count      (err_count),
        .o_first_fail_addr(ffa)
    );

    // Memory: synchronous write, read data registered (valid the next cycle).
    always @(posedge clk) begin
        if (wr) mem[addr] <= din;
        if (rd) dout <= fault_en[addr] ? fault_val[addr] : mem[addr];
    end

    function automatic logic [7:0] ref_pat(input logic [1:0] m, input logic [7:0] s,
                                           input int a);
        case (m)
            2'b00:   return 8'h00;
            2'b01:   return 8'hFF;
            2'b10:   return (a % 2 == 0) ? 8'h55 : 8'hAA;
            default: return s ^ 8'(a);
        endcase
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < 32; a++) begin
            fault_en[a]  = 1'b0;
            fault_val[a] = 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full test from IDLE/DONE and checks every cycle up to cycle 66.
    // poke >= 1 pulses a conflicting start in that cycle.
    task automatic run_bist(input logic [1:0] m, input logic [7:0] s, input int poke,
                            input string name);
        logic [7:0]  pat [32];
        logic [7:0]  ret;
        int          exp_err;
        int          exp_first;
        int          d;
        logic        ew, er;
        logic [4:0]  ea;
        logic [7:0]  ed;
        logic [16:0] exp_v, got_v;
        exp_err   = 0;
        exp_first = 0;
        for (int a = 0; a < 32; a++) begin
            pat[a] = ref_pat(m, s, a);
            ret    = fault_en[a] ? fault_val[a] : pat[a];
            if (ret != pat[a]) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        d = 66;
`ifdef MEM_BIST_STOP_ON_ERR_EN
        if (exp_err > 0) begin
            exp_err = 1;
            if (35 + exp_first < 66) d = 35 + exp_first;
        end
`endif
        start = 1'b1;
        mode  = m;
        seed  = s;
        step();
        start = 1'b0;
        mode  = 2'($urandom);
        seed  = 8'($urandom);
        n_checks++;
        if ({done, pass, err_count, ffa} !== 13'd0) begin
            n_errors++;
            $display("FAIL %s clear-on-start: got done=%0b pass=%0b err=%0d ffa=%0d want all 0",
                     name, done, pass, err_count, ffa);
        end
        for (int n = 1; n <= 66; n++) begin
            ew = (n >= 1 && n <= 32);
            er = (n >= 33 && n <= 64 && n < d);
            ea = ew ? 5'(n - 1) : (er ? 5'(n - 33) : 5'd0);
            ed = ew ? pat[n - 1] : 8'h00;
            exp_v = {er, ew, ea, ed, (n < d), (n >= d)};
            got_v = {rd, wr, addr, din, busy, done};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got rd=%0b wr=%0b addr=%0d din=%h busy=%0b done=%0b want rd=%0b wr=%0b addr=%0d din=%h busy=%0b done=%0b",
                         name, n, rd, wr, addr, din, busy, done,
                         er, ew, ea, ed, (n < d), (n >= d));
            end
            if (n < 66) begin
                if (n == poke) begin
                    start = 1'b1;
                    mode  = ~m;
                    seed  = ~s;
                end
                step();
                start = 1'b0;
            end
        end
        n_checks++;
        if (pass !== (exp_err == 0) || err_count !== 6'(exp_err) || ffa !== 5'(exp_first)) begin
            n_errors++;
            $display("FAIL %s result: got pass=%0b err=%0d ffa=%0d want pass=%0b err=%0d ffa=%0d",
                     name, pass, err_count, ffa, (exp_err == 0), exp_err, exp_first);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        seed  = 8'h00;
        repeat (3) step();
        n_checks++;
        if ({rd, wr, addr, din, busy, done, pass, err_count, ffa} !== 31'd0) begin
            n_errors++;
            $display("FAIL reset: got rd=%0b wr=%0b addr=%0d din=%h busy=%0b done=%0b pass=%0b err=%0d ffa=%0d want all 0",
                     rd, wr, addr, din, busy, done, pass, err_count, ffa);
        end
        // Reset wins over a simultaneous start.
        start = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        n_checks++;
        if ({busy, wr} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_vs_start: got busy=%0b wr=%0b want 0 0", busy, wr);
        end
        step();
    endtask

    task automatic test_all_zero();
        clear_faults();
        run_bist(2'b00, 8'h00, 0, "all_zero");
    endtask

    task automatic test_checker_fault();
        clear_faults();
        fault_en[7]   = 1'b1;
        fault_val[7]  = 8'h54;
        fault_en[20]  = 1'b1;
        fault_val[20] = 8'hAB;
        run_bist(2'b10, 8'h00, 0, "checker_fault");
        clear_faults();
    endtask

    task automatic test_seeded();
        clear_faults();
        run_bist(2'b11, 8'hA0, 0, "seeded_a0");
    endtask

    task automatic test_mid_reset();
        clear_faults();
        start = 1'b1;
        mode  = 2'b01;
        step();
        start = 1'b0;
        repeat (9) step();
        n_checks++;
        if (wr !== 1'b1 || addr !== 5'd9) begin
            n_errors++;
            $display("FAIL mid_reset pre: got wr=%0b addr=%0d want 1 9", wr, addr);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({wr, rd, busy, done, addr, din} !== 17'd0) begin
            n_errors++;
            $display("FAIL mid_reset post: got wr=%0b rd=%0b busy=%0b done=%0b addr=%0d din=%h want all 0",
                     wr, rd, busy, done, addr, din);
        end
        rst = 1'b0;
        step();
        run_bist(2'b01, 8'h00, 0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        clear_faults();
        run_bist(2'b10, 8'h3C, 40, "start_busy");
        run_bist(2'b11, 8'h5A, 10, "start_busy_write");
    endtask

    task automatic test_back_to_back();
        clear_faults();
        fault_en[3]  = 1'b1;
        fault_val[3] = 8'h01;
        run_bist(2'b01, 8'h00, 0, "b2b_fail");
        clear_faults();
        repeat (3) step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_hold: got done=%0b busy=%0b want 1 0", done, busy);
        end
        run_bist(2'b00, 8'h00, 0, "b2b_rerun");
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [7:0] s;
        for (int it = 0; it < 8; it++) begin
            m = 2'($urandom);
            s = 8'($urandom);
            for (int a = 0; a < 32; a++) begin
                fault_en[a]  = ($urandom_range(0, 7) == 0);
                fault_val[a] = ref_pat(m, s, a) ^ 8'($urandom_range(1, 255));
            end
            run_bist(m, s, 0, "random");
        end
        clear_faults();
    endtask

    initial begin
        clear_faults();
        for (int a = 0; a < 32; a++) mem[a] = 8'h00;
        dout = 8'h00;
        test_reset();
        test_all_zero();
        test_checker_fault();
        test_seeded();
        test_mid_reset();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
